// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// o_ovf exists only when PIPELINED_ADDER_OVF_EN is defined.
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             o_ovf;

    modport slave (
        input  i_valid, i_a, i_b, i_cin, i_sub, i_ready,
        output o_ready, o_valid, o_sum, o_cout, o_ovf
    );
    modport master (
        output i_valid, i_a, i_b, i_cin, i_sub, i_ready,
        input  o_ready, o_valid, o_sum, o_cout, o_ovf
    );
`else
    modport slave (
        input  i_valid, i_a, i_b, i_cin, i_sub, i_ready,
        output o_ready, o_valid, o_sum, o_cout
    );
    modport master (
        output i_valid, i_a, i_b, i_cin, i_sub, i_ready,
        input  o_ready, o_valid, o_sum, o_cout
    );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: WIDTH-bit ripple carry split into WIDTH/CHUNK registered stages.
// Define PIPELINED_ADDER_OVF_EN to add the signed-overflow output o_ovf.
module pipelined_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    pipelined_adder_if.slave bus
);
    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int unsigned LAST   = STAGES - 1;

    if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
        $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
    end

    logic adv;

    // Per-stage registers; a_q/b_q carry the operands forward so later stages
    // can still see the chunks they have not added yet.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];

    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];
    logic             c_src [STAGES];
    logic             v_src [STAGES];
    logic [WIDTH-1:0] s_nxt [STAGES];
    logic             c_nxt [STAGES];
    logic [CHUNK:0]   part  [STAGES];

    assign adv         = !v_q[LAST] || bus.i_ready;
    assign bus.o_ready = adv;
    assign bus.o_valid = v_q[LAST];
    assign bus.o_sum   = s_q[LAST];
    assign bus.o_cout  = c_q[LAST];

    always_comb begin
        a_src[0] = bus.i_a;
        b_src[0] = bus.i_sub ? ~bus.i_b : bus.i_b;
        c_src[0] = bus.i_sub | bus.i_cin;
        s_src[0] = '0;
        v_src[0] = bus.i_valid && adv;
        for (int unsigned k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            c_src[k] = c_q[k-1];
            s_src[k] = s_q[k-1];
            v_src[k] = v_q[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                    + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, c_src[k]};
            s_nxt[k] = s_src[k];
            s_nxt[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
            c_nxt[k] = part[k][CHUNK];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= v_src[k];
                s_q[k] <= s_nxt[k];
                c_q[k] <= c_nxt[k];
            end
        end
    end

    // Operand skew registers need no reset: their contents only matter behind a valid bit.
    always_ff @(posedge i_clk) begin
        if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
            end
        end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    logic ovf_nxt;
    logic ovf_q;

    // Carry into the MSB is recovered from the MSB operand bits and its sum bit.
    always_comb begin
        ovf_nxt = (a_src[LAST][WIDTH-1] ^ b_src[LAST][WIDTH-1] ^ part[LAST][CHUNK-1])
                ^ part[LAST][CHUNK];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_nxt;
        end
    end

    assign bus.o_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=16, CHUNK=4).
// Overflow checks are active when PIPELINED_ADDER_OVF_EN is defined.
module tb_pipelined_adder;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CHUNK  = 4;
    localparam int unsigned STAGES = 4;
`ifdef PIPELINED_ADDER_OVF_EN
    localparam logic [17:0] MASK = 18'h3FFFF;
`else
    localparam logic [17:0] MASK = 18'h1FFFF;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [15:0] sa   [16];
    logic [15:0] sb   [16];
    logic        scin [16];
    logic        ssub [16];

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {ovf, cout, sum}
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] be;
        logic [16:0] full;
        logic        ovf;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {16'd0, (sub ? 1'b1 : cin)};
        ovf  = (a[15] == be[15]) && (full[15] != a[15]);
        return {ovf, full} & MASK;
    endfunction

    function automatic logic [17:0] observed();
`ifdef PIPELINED_ADDER_OVF_EN
        return {bus.o_ovf, bus.o_cout, bus.o_sum};
`else
        return {1'b0, bus.o_cout, bus.o_sum};
`endif
    endfunction

    task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [17:0] exp);
        int unsigned lat;
        @(negedge clk);
        bus.i_ready = 1'b1;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_cin   = cin;
        bus.i_sub   = sub;
        bus.i_valid = 1'b1;
        #1 check({tag, "/ready"}, 32'(bus.o_ready), 32'd1);
        @(negedge clk);
        bus.i_valid = 1'b0;
        lat = 1;
        #1;
        while (!bus.o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            #1;
        end
        check({tag, "/lat"}, lat, STAGES);
        check({tag, "/res"}, 32'(observed()), 32'(exp & MASK));
    endtask

    task automatic run_stream(input string tag, input int unsigned n,
                              input int unsigned stall_at, input int unsigned stall_len,
                              output int unsigned lat, output int unsigned span);
        logic [17:0] exp_q[$];
        logic [17:0] held_val;
        bit          held;
        bit          seen_out;
        int unsigned sent, got, cyc, first_acc, first_out, last_out;
        sent = 0; got = 0; cyc = 0; first_acc = 0; first_out = 0; last_out = 0;
        held = 1'b0; seen_out = 1'b0; held_val = '0;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            bus.i_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (sent < n) begin
                bus.i_valid = 1'b1;
                bus.i_a     = sa[sent];
                bus.i_b     = sb[sent];
                bus.i_cin   = scin[sent];
                bus.i_sub   = ssub[sent];
            end else begin
                bus.i_valid = 1'b0;
            end
            #1;
            if (held) check({tag, "/hold"}, 32'(observed()), 32'(held_val));
            held = 1'b0;
            if (bus.o_valid) begin
                if (bus.i_ready) begin
                    if (exp_q.size() != 0)
                        check({tag, "/order"}, 32'(observed()), 32'(exp_q.pop_front()));
                    else
                        check({tag, "/extra"}, exp_q.size(), 32'd1);
                    if (!seen_out) first_out = cyc;
                    seen_out = 1'b1;
                    last_out = cyc;
                    got++;
                end else begin
                    check({tag, "/oready"}, 32'(bus.o_ready), 32'd0);
                    held     = 1'b1;
                    held_val = observed();
                end
            end
            if (bus.i_valid && bus.o_ready) begin
                exp_q.push_back(model(bus.i_a, bus.i_b, bus.i_cin, bus.i_sub));
                if (sent == 0) first_acc = cyc;
                sent++;
            end
            cyc++;
        end
        bus.i_valid = 1'b0;
        check({tag, "/count"}, got, n);
        check({tag, "/left"}, exp_q.size(), 32'd0);
        lat  = first_out - first_acc;
        span = last_out - first_out;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat, span, nval;
        for (int i = 0; i < 16; i++) begin
            sa[i]   = 16'((i * 32'h9E37) ^ 32'h5A5A);
            sb[i]   = 16'((i * 32'h3C6F) + 32'h0F0F);
            scin[i] = (i & 1) != 0;
            ssub[i] = (i & 2) != 0;
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_cin   = 1'b0;
        bus.i_sub   = 1'b0;

        #2;
        check("rst/valid", 32'(bus.o_valid), 32'd0);
        check("rst/res",   32'(observed()),  32'd0);
        check("rst/ready", 32'(bus.o_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        single("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        single("sub1",     16'h1234, 16'h0235, 1'b0, 1'b1, {1'b0, 1'b1, 16'h0FFF});
        single("sub2",     16'h0001, 16'h0002, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFF});
        single("addcin",   16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 16'h5556});
        single("subigcin", 16'h0005, 16'h0003, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0002});
        single("allones",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {1'b0, 1'b1, 16'hFFFF});
        single("chunkc",   16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100});
        single("ovf1",     16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        single("ovf2",     16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        single("ovf0",     16'h0003, 16'h0004, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0007});

        run_stream("stream", 16, 1000, 0, lat, span);
        check("stream/lat",  lat,  STAGES);
        check("stream/span", span, 32'd15);

        run_stream("bp", 8, 6, 5, lat, span);
        check("bp/lat", lat, STAGES);

        // Reset mid-flight: three tokens in, first one parked at the output.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.i_ready = 1'b1;
            bus.i_valid = 1'b1;
            bus.i_a     = 16'h1111 * 16'(i + 1);
            bus.i_b     = 16'h2222;
            bus.i_cin   = 1'b0;
            bus.i_sub   = 1'b0;
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        @(negedge clk);
        #1;
        check("mid/pre_valid", 32'(bus.o_valid), 32'd1);
        check("mid/pre_sum",   32'(bus.o_sum),   32'h3333);
        #2 rst_n = 1'b0;
        #1;
        check("mid/valid", 32'(bus.o_valid), 32'd0);
        check("mid/res",   32'(observed()),  32'd0);
        check("mid/ready", 32'(bus.o_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        nval = 0;
        repeat (10) begin
            @(negedge clk);
            #1 if (bus.o_valid) nval++;
        end
        check("mid/stale", nval, 32'd0);
        single("mid/after", 16'hABCD, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 16'hBCDE});

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
